// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier among N_REQ requesters.
// The pipeline has two stages: an operand register (p1) and a result register (p2).

module mydesign_comb #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 4
) (
  input  logic [N_IN-1:0]  a,
  input  logic [N_IN-1:0]  b,
  output logic [N_OUT-1:0] y
);
  assign y = N_OUT'(a) * N_OUT'(b);
endmodule

module mult_share_arbiter #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 4,
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                  clk_ci,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*N_IN-1:0] req_a_i,
  input  logic [N_REQ*N_IN-1:0] req_b_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [ID_W-1:0]       resp_id_o,
  output logic [N_OUT-1:0]      resp_result_o,
  output logic                  busy_o
);

  if (N_OUT != 2 * N_IN) begin : g_bad_width
    $error("mult_share_arbiter: N_OUT must equal 2*N_IN");
  end
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("mult_share_arbiter: N_REQ must be in 2..16");
  end

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx);
    if (int'(idx) == N_REQ - 1) wrap_inc = '0;
    else                        wrap_inc = idx + ID_W'(1);
  endfunction

  logic [ID_W-1:0]  ptr;
  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic             adv_p1, adv_p2, xfer;

  logic             vld_p1;
  logic [N_IN-1:0]  a_p1, b_p1;
  logic [ID_W-1:0]  id_p1;

  logic             vld_p2;
  logic [N_OUT-1:0] result_p2;
  logic [ID_W-1:0]  id_p2;

  logic [N_OUT-1:0] mult_y;

  assign adv_p2 = !vld_p2 || resp_ready_i;
  assign adv_p1 = !vld_p1 || adv_p2;
  assign xfer   = rst_ni && adv_p1 && grant_vld;

  // Rotating priority search starting at ptr
  always_comb begin
    int unsigned j;
    j         = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!grant_vld && req_valid_i[j]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(j);
      end
    end
  end

  assign req_ready_o = xfer ? (N_REQ'(1) << grant_id) : '0;

  (* dont_touch = "true" *)
  mydesign_comb #(.N_IN(N_IN), .N_OUT(N_OUT)) u_mult (
    .a (a_p1),
    .b (b_p1),
    .y (mult_y)
  );

  always_ff @(posedge clk_ci) begin
    if (!rst_ni) begin
      ptr       <= '0;
      vld_p1    <= 1'b0;
      a_p1      <= '0;
      b_p1      <= '0;
      id_p1     <= '0;
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      id_p2     <= '0;
    end else begin
      // Stage boundary: request -> operand register
      if (adv_p1) begin
        vld_p1 <= xfer;
        if (xfer) begin
          a_p1  <= req_a_i[int'(grant_id)*N_IN +: N_IN];
          b_p1  <= req_b_i[int'(grant_id)*N_IN +: N_IN];
          id_p1 <= grant_id;
          ptr   <= wrap_inc(grant_id);
        end
      end
      // Stage boundary: operand register -> result register
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          result_p2 <= mult_y;
          id_p2     <= id_p1;
        end
      end
    end
  end

  assign resp_valid_o  = vld_p2;
  assign resp_id_o     = id_p2;
  assign resp_result_o = result_p2;
  assign busy_o        = vld_p1 | vld_p2;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with hand-computed expectations.

module tb_mult_share_arbiter;
  logic       clk_ci = 1'b0;
  logic       rst_ni;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [7:0] req_a, req_b;
  logic       resp_valid, resp_ready;
  logic [1:0] resp_id;
  logic [3:0] resp_result;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_ci = ~clk_ci;

  mult_share_arbiter #(.N_IN(2), .N_OUT(4), .N_REQ(4)) dut (
    .clk_ci        (clk_ci),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_a_i       (req_a),
    .req_b_i       (req_b),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_id_o     (resp_id),
    .resp_result_o (resp_result),
    .busy_o        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ci);
    #1;
  endtask

  task automatic ready_is(input string tag, input logic [3:0] exp);
    #1;
    check(tag, req_ready, exp);
  endtask

  task automatic resp_is(input string tag, input logic [1:0] id, input logic [3:0] res);
    check({tag, "_vld"}, resp_valid, 1'b1);
    check({tag, "_id"}, resp_id, id);
    check({tag, "_res"}, resp_result, res);
  endtask

  task automatic set_op(input int k, input logic [1:0] a, input logic [1:0] b);
    req_a[k*2 +: 2] = a;
    req_b[k*2 +: 2] = b;
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni     = 1'b0;
    req_valid  = 4'b1111;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    // Reset state; ready stays low while reset is asserted even with valids high
    tick();
    tick();
    ready_is("rst_ready", 4'b0000);
    check("rst_vld", resp_valid, 1'b0);
    check("rst_id", resp_id, 2'd0);
    check("rst_res", resp_result, 4'd0);
    check("rst_busy", busy, 1'b0);
    rst_ni    = 1'b1;
    req_valid = '0;
    tick();

    // Single request from requester 2: 3*2
    set_op(2, 2'd3, 2'd2);
    req_valid = 4'b0100;
    ready_is("single_ready", 4'b0100);
    tick();
    req_valid = '0;
    check("single_busy", busy, 1'b1);
    check("single_vld_early", resp_valid, 1'b0);
    tick();
    resp_is("single", 2'd2, 4'd6);
    tick();
    check("single_drain", resp_valid, 1'b0);
    check("single_idle", busy, 1'b0);

    // Pointer now at 3: valids 0101 grant 0, then 2
    set_op(0, 2'd1, 2'd2);
    set_op(2, 2'd2, 2'd3);
    req_valid = 4'b0101;
    ready_is("wrap_ready0", 4'b0001);
    tick();
    ready_is("wrap_ready2", 4'b0100);
    tick();
    req_valid = '0;
    resp_is("wrap_r0", 2'd0, 4'd2);
    tick();
    resp_is("wrap_r2", 2'd2, 4'd6);
    tick();

    // All-valid round robin, requester k sends k*3
    do_reset();
    for (int k = 0; k < 4; k++) set_op(k, 2'(k), 2'd3);
    for (int i = 0; i < 10; i++) begin
      req_valid = (i < 8) ? 4'b1111 : 4'b0000;
      ready_is($sformatf("rr_ready%0d", i), (i < 8) ? (4'b0001 << (i % 4)) : 4'b0000);
      tick();
      if (i >= 1 && i <= 8)
        resp_is($sformatf("rr_resp%0d", i), 2'((i - 1) % 4), 4'(3 * ((i - 1) % 4)));
    end
    check("rr_done", resp_valid, 1'b0);

    // Backpressure: 1x1, 2x2, 3x3 with the consumer stalled for 5 cycles
    do_reset();
    set_op(0, 2'd1, 2'd1);
    set_op(1, 2'd2, 2'd2);
    set_op(2, 2'd3, 2'd3);
    resp_ready = 1'b0;
    req_valid  = 4'b0111;
    ready_is("bp_ready0", 4'b0001);
    tick();
    req_valid = 4'b0110;
    check("bp_vld_early", resp_valid, 1'b0);
    ready_is("bp_ready1", 4'b0010);
    tick();
    req_valid = 4'b0100;
    resp_is("bp_hold_first", 2'd0, 4'd1);
    for (int i = 0; i < 3; i++) begin
      ready_is($sformatf("bp_stall_ready%0d", i), 4'b0000);
      tick();
      resp_is($sformatf("bp_hold%0d", i), 2'd0, 4'd1);
    end
    resp_ready = 1'b1;
    ready_is("bp_release_ready", 4'b0100);
    tick();
    req_valid = '0;
    resp_is("bp_r1", 2'd1, 4'd4);
    tick();
    resp_is("bp_r2", 2'd2, 4'd9);
    tick();
    check("bp_done_vld", resp_valid, 1'b0);
    check("bp_done_busy", busy, 1'b0);

    // Boundary operands: 3*3 from requester 3, 0*3 from requester 1
    do_reset();
    set_op(3, 2'd3, 2'd3);
    set_op(1, 2'd0, 2'd3);
    req_valid = 4'b1010;
    ready_is("bnd_ready1", 4'b0010);
    tick();
    req_valid = 4'b1000;
    ready_is("bnd_ready3", 4'b1000);
    tick();
    req_valid = '0;
    resp_is("bnd_r1", 2'd1, 4'd0);
    tick();
    resp_is("bnd_r3", 2'd3, 4'b1001);
    tick();

    // Reset while both stages hold data
    do_reset();
    set_op(0, 2'd1, 2'd3);
    set_op(1, 2'd2, 2'd1);
    set_op(2, 2'd1, 2'd1);
    resp_ready = 1'b0;
    req_valid  = 4'b0011;
    ready_is("mid_ready0", 4'b0001);
    tick();
    req_valid = 4'b0010;
    ready_is("mid_ready1", 4'b0010);
    tick();
    check("mid_full_busy", busy, 1'b1);
    rst_ni    = 1'b0;
    req_valid = 4'b1111;
    ready_is("mid_rst_ready", 4'b0000);
    tick();
    check("mid_vld", resp_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    rst_ni     = 1'b1;
    resp_ready = 1'b1;
    req_valid  = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_no_stale%0d", i), resp_valid, 1'b0);
    end
    req_valid = 4'b0101;
    ready_is("mid_ptr0", 4'b0001);
    tick();
    req_valid = '0;
    tick();
    resp_is("mid_after", 2'd0, 4'd3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
